// File: rtl/apc_stream_accumulator.sv
// apc_stream_accumulator
//   Converts the per-cycle popcount of a 31-input approximate parallel counter
//   back to binary. It sums STREAM_LEN accepted samples into one window result,
//   which is handed to the PE result register over a valid/ready handshake.
//
//   Build option: define APC_ACC_BIPOLAR_EN for bipolar decoding of the window
//   result: result = 2*acc - (2^SUM_W-1)*STREAM_LEN, in two's complement.
//   With the macro undefined the result is unipolar: {1'b0, acc}.
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      begin a window (honoured in IDLE or with the DONE handshake)
//     clear      synchronous abort back to IDLE; overrides start/handshake
//     apc_sum    popcount sample from the APC
//     in_valid   apc_sum is valid this cycle
//     in_ready   block is accumulating (ACCUM)
//     result     window result, held while out_valid is high
//     out_valid  result available (DONE)
//     out_ready  consumer takes the result
//     busy       not idle
//
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | summing accepted samples, in_ready high
//   DONE  | result presented, waiting for out_ready
module apc_stream_accumulator #(
  parameter int SUM_W      = 5,
  parameter int LEN_W      = 8,
  parameter int STREAM_LEN = 256,
  parameter int ACC_W      = SUM_W + LEN_W,
  parameter int RES_W      = ACC_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [SUM_W-1:0] apc_sum,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [RES_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(STREAM_LEN - 1);
  localparam int               FULL_INT = ((1 << SUM_W) - 1) * STREAM_LEN;
  localparam logic [RES_W-1:0] FULL_SCALE = RES_W'(FULL_INT);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [RES_W-1:0] result_nxt;
  logic [ACC_W-1:0] acc_sum;
  logic [RES_W-1:0] result_map;

  // Sum including the current sample; on the last sample this is the final value.
  assign acc_sum = acc + ACC_W'(apc_sum);

`ifdef APC_ACC_BIPOLAR_EN
  // 2*acc - full scale; wraps naturally into two's complement at RES_W bits.
  assign result_map = {acc_sum, 1'b0} - FULL_SCALE;
`else
  assign result_map = {1'b0, acc_sum};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    result_nxt = result;
    if (clear) begin
      // result deliberately keeps its last value across an abort
      state_nxt = ST_IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_nxt = acc_sum;
            if (cnt == LAST_CNT) begin
              // cnt is left at its last value so it never wraps
              result_nxt = result_map;
              state_nxt  = ST_DONE;
            end else begin
              cnt_nxt = cnt + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (start) begin
              state_nxt = ST_ACCUM;
              acc_nxt   = '0;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_apc_stream_accumulator.sv
module tb_apc_stream_accumulator;

  localparam int SUM_W = 5;
  localparam int LEN_W = 8;
  localparam int L     = 256;
  localparam int ACC_W = SUM_W + LEN_W;
  localparam int RES_W = ACC_W + 1;
  localparam int FULL  = 31 * L;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic [SUM_W-1:0] apc_sum = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [RES_W-1:0] result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  int checks = 0;
  int failures = 0;

  apc_stream_accumulator #(
    .SUM_W(SUM_W), .LEN_W(LEN_W), .STREAM_LEN(L), .ACC_W(ACC_W), .RES_W(RES_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .apc_sum(apc_sum), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference mapping of a plain integer window sum to the result port.
  function automatic logic [RES_W-1:0] expect_of(input int sum);
`ifdef APC_ACC_BIPOLAR_EN
    return RES_W'(2 * sum - FULL);
`else
    return RES_W'(sum);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start cycle offers a valid sample that must not be summed.
  task automatic do_start();
    start = 1'b1; apc_sum = 5'd31; in_valid = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Feed one full window. mode 0: constant val, 1: alternating 15/16 with a
  // bubble every third cycle, 2: random values, random bubbles, random start.
  task automatic feed(input int mode, input int val, output int sum, output int early);
    int k = 0;
    int c = 0;
    int v;
    logic vld;
    sum = 0;
    early = 0;
    while (k < L) begin
      case (mode)
        0: begin vld = 1'b1; v = val; end
        1: begin vld = (c % 3 != 2); v = (k % 2 == 0) ? 15 : 16; end
        default: begin
          vld = ($urandom_range(0, 3) != 0);
          v = $urandom_range(0, 31);
          start = $urandom_range(0, 1) == 1;
        end
      endcase
      apc_sum = SUM_W'(v);
      in_valid = vld;
      if (vld) begin sum += v; k++; end
      if (out_valid !== 1'b0 || in_ready !== 1'b1) early++;
      step();
      c++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || result !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b in_ready=%b out_valid=%b result=%0d want 0", busy, in_ready, out_valid, result);
    end
    #14 rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_full_scale(input int val, input string name);
    int sum, early;
    do_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_enter in_ready=%b busy=%b want 1 1", name, in_ready, busy);
    end
    feed(0, val, sum, early);
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL %s_accum_flags bad_cycles=%0d want 0", name, early);
    end
    checks++;
    if (out_valid !== 1'b1 || result !== expect_of(val * L)) begin
      failures++;
      $display("FAIL %s_result out_valid=%b result=%h want 1 %h", name, out_valid, result, expect_of(val * L));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_handshake busy=%b out_valid=%b want 0 0", name, busy, out_valid);
    end
  endtask

  task automatic test_bubbles();
    int sum, early;
    do_start();
    feed(1, 0, sum, early);
    checks++;
    if (sum != 3968 || early != 0) begin
      failures++;
      $display("FAIL bubbles_model sum=%0d bad=%0d want 3968 0", sum, early);
    end
    checks++;
    if (out_valid !== 1'b1 || result !== expect_of(3968)) begin
      failures++;
      $display("FAIL bubbles_result out_valid=%b result=%h want 1 %h", out_valid, result, expect_of(3968));
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    int sum, early;
    for (int w = 0; w < 2; w++) begin
      do_start();
      feed(2, 0, sum, early);
      checks++;
      if (out_valid !== 1'b1 || result !== expect_of(sum) || early != 0) begin
        failures++;
        $display("FAIL random_window%0d out_valid=%b result=%h bad=%0d want 1 %h 0", w, out_valid, result, early, expect_of(sum));
      end
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int sum, early;
    logic [RES_W-1:0] exp1;
    do_start();
    feed(0, 31, sum, early);
    exp1 = expect_of(sum);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      apc_sum = SUM_W'($urandom_range(0, 31));
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp1) begin
        failures++;
        $display("FAIL hold_cycle%0d out_valid=%b in_ready=%b result=%h want 1 0 %h", i, out_valid, in_ready, result, exp1);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1; start = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    feed(2, 0, sum, early);
    checks++;
    if (out_valid !== 1'b1 || result !== expect_of(sum)) begin
      failures++;
      $display("FAIL b2b_second out_valid=%b result=%h want 1 %h", out_valid, result, expect_of(sum));
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_clear();
    int sum, early;
    logic [RES_W-1:0] prev;
    prev = result;
    do_start();
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; apc_sum = 5'd7;
      step();
    end
    in_valid = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== prev) begin
      failures++;
      $display("FAIL clear_abort busy=%b out_valid=%b result=%h want 0 0 %h", busy, out_valid, result, prev);
    end
    do_start();
    feed(0, 1, sum, early);
    checks++;
    if (out_valid !== 1'b1 || result !== expect_of(256)) begin
      failures++;
      $display("FAIL clear_fresh result=%h out_valid=%b want %h 1", result, out_valid, expect_of(256));
    end
    clear = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; start = 1'b0; out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== expect_of(256)) begin
      failures++;
      $display("FAIL clear_priority busy=%b out_valid=%b result=%h want 0 0 %h", busy, out_valid, result, expect_of(256));
    end
  endtask

  task automatic test_async_reset();
    int sum, early;
    do_start();
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; apc_sum = SUM_W'($urandom_range(0, 31));
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || result !== '0) begin
      failures++;
      $display("FAIL async_reset busy=%b in_ready=%b out_valid=%b result=%h want 0", busy, in_ready, out_valid, result);
    end
    #2 rst_n = 1'b1;
    step();
    do_start();
    feed(2, 0, sum, early);
    checks++;
    if (out_valid !== 1'b1 || result !== expect_of(sum)) begin
      failures++;
      $display("FAIL async_after result=%h out_valid=%b want %h 1", result, out_valid, expect_of(sum));
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scale(31, "full31");
    test_full_scale(0, "zero");
    test_bubbles();
    test_random();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
